// File: rtl/qbus_pkg.sv
// Shared encodings for the Q-bus master arbiter: bus cycle states, bus owner
// and the reply timeout limit.
package qbus_pkg;

    typedef enum logic [2:0] {
        BS_IDLE,
        BS_ADDR,
        BS_RD,
        BS_WR,
        BS_DONE,
        BS_ERR,
        BS_DMA_REQ,
        BS_DMA_OWN
    } bus_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_F,
        OWN_O
    } owner_t;

    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] TIMEOUT = 6'd63;

endpackage

// File: rtl/qbus_master_arb_sync2.sv
// Two-flop synchronizer for the asynchronous Q-bus handshake inputs.
// The reset value is the line's idle level so nothing looks asserted at reset.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/qbus_master_arb.sv
// CPU-side Q-bus master: arbitrates DMA, operand and fetch requesters and
// sequences each granted read/write cycle with a reply timeout.
module qbus_master_arb
    import qbus_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        f_req,
    input  logic [15:0] f_addr,
    output logic        f_done,
    output logic        f_err,
    input  logic        o_req,
    input  logic        o_wr,
    input  logic        o_byte,
    input  logic [15:0] o_addr,
    input  logic [15:0] o_wdata,
    output logic        o_done,
    output logic        o_err,
    output logic [15:0] rdata,
    input  logic        dmr,
    input  logic        sack,
    input  logic        rply,
    output logic        dmgo,
    output logic        sync,
    output logic        din,
    output logic        dout,
    output logic        wtbt,
    output logic [15:0] ad_o,
    output logic        ad_oe,
    input  logic [15:0] ad_i
);

    bus_state_t        state, next_state;
    owner_t            owner, next_owner;
    logic              dmr_s, sack_s, rply_s;
    logic              done_seen;
    logic [CNT_W-1:0]  cnt;
    logic [15:0]       cur_addr, cur_wdata;
    logic              cur_wr, cur_byte;

    sync2 #(.RST_VAL(1'b1)) u_sync_dmr  (.clk(clk), .reset(reset), .d(dmr),  .q(dmr_s));
    sync2 #(.RST_VAL(1'b1)) u_sync_sack (.clk(clk), .reset(reset), .d(sack), .q(sack_s));
    sync2 #(.RST_VAL(1'b1)) u_sync_rply (.clk(clk), .reset(reset), .d(rply), .q(rply_s));

    // done_seen marks every clock after the first in DONE so the pulse lasts one clock
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= BS_IDLE;
            owner     <= OWN_NONE;
            done_seen <= 1'b0;
        end else begin
            state     <= next_state;
            owner     <= next_owner;
            done_seen <= (state == BS_DONE);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            rdata     <= '0;
            cur_addr  <= '0;
            cur_wdata <= '0;
            cur_wr    <= 1'b0;
            cur_byte  <= 1'b0;
        end else begin
            if (state == BS_IDLE && next_state == BS_ADDR) begin
                if (next_owner == OWN_O) begin
                    cur_addr  <= o_addr;
                    cur_wdata <= o_wdata;
                    cur_wr    <= o_wr;
                    cur_byte  <= o_byte;
                end else begin
                    cur_addr  <= f_addr;
                    cur_wdata <= '0;
                    cur_wr    <= 1'b0;
                    cur_byte  <= 1'b0;
                end
            end
            if (state == BS_ADDR) begin
                cnt <= '0;
            end else if (state == BS_RD || state == BS_WR) begin
                cnt <= cnt + 1'b1;
            end
            if (state == BS_RD && !rply_s) begin
                rdata <= ad_i;
            end
        end
    end

    // A reply on the same clock as the timeout still completes the cycle
    always_comb begin
        next_state = state;
        next_owner = owner;
        case (state)
            BS_IDLE: begin
                if (!dmr_s) begin
                    next_state = BS_DMA_REQ;
                end else if (o_req) begin
                    next_state = BS_ADDR;
                    next_owner = OWN_O;
                end else if (f_req) begin
                    next_state = BS_ADDR;
                    next_owner = OWN_F;
                end
            end
            BS_ADDR:    next_state = cur_wr ? BS_WR : BS_RD;
            BS_RD, BS_WR: begin
                if (!rply_s) begin
                    next_state = BS_DONE;
                end else if (cnt == TIMEOUT) begin
                    next_state = BS_ERR;
                end
            end
            BS_DONE: begin
                if (rply_s) begin
                    next_state = BS_IDLE;
                    next_owner = OWN_NONE;
                end
            end
            BS_ERR: begin
                next_state = BS_IDLE;
                next_owner = OWN_NONE;
            end
            BS_DMA_REQ: begin
                if (!sack_s) begin
                    next_state = BS_DMA_OWN;
                end else if (dmr_s) begin
                    next_state = BS_IDLE;
                end
            end
            BS_DMA_OWN: begin
                if (sack_s) begin
                    next_state = BS_IDLE;
                end
            end
            default: begin
                next_state = BS_IDLE;
                next_owner = OWN_NONE;
            end
        endcase
    end

    always_comb begin
        sync   = 1'b1;
        din    = 1'b1;
        dout   = 1'b1;
        wtbt   = 1'b1;
        dmgo   = 1'b1;
        ad_oe  = 1'b0;
        ad_o   = '0;
        f_done = 1'b0;
        f_err  = 1'b0;
        o_done = 1'b0;
        o_err  = 1'b0;
        case (state)
            BS_ADDR: begin
                ad_oe = 1'b1;
                ad_o  = cur_addr;
                wtbt  = ~cur_wr;
            end
            BS_RD: begin
                sync = 1'b0;
                din  = 1'b0;
                wtbt = ~cur_byte;
            end
            BS_WR: begin
                sync  = 1'b0;
                dout  = 1'b0;
                ad_oe = 1'b1;
                ad_o  = cur_wdata;
                wtbt  = ~cur_byte;
            end
            BS_DONE: begin
                sync = 1'b0;
                if (!done_seen) begin
                    f_done = (owner == OWN_F);
                    o_done = (owner == OWN_O);
                end
            end
            BS_ERR: begin
                f_err = (owner == OWN_F);
                o_err = (owner == OWN_O);
            end
            BS_DMA_REQ: dmgo = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_qbus_master_arb.sv
// Directed bench for qbus_master_arb: a hand-driven slave and DMA master walk
// the bus through reads, writes, arbitration, timeout, DMA hand-off and reset.
module tb_qbus_master_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req, o_req, o_wr, o_byte;
    logic [15:0] f_addr, o_addr, o_wdata, ad_i;
    logic        f_done, f_err, o_done, o_err;
    logic [15:0] rdata, ad_o;
    logic        dmr, sack, rply, dmgo, sync, din, dout, wtbt, ad_oe;

    int total = 0;
    int bad = 0;
    int f_done_cnt = 0;
    int o_done_cnt = 0;
    int f_err_cnt = 0;
    int o_err_cnt = 0;
    logic multi_pulse = 1'b0;

    always #5 clk = ~clk;

    qbus_master_arb dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_err(f_err),
        .o_req(o_req), .o_wr(o_wr), .o_byte(o_byte), .o_addr(o_addr),
        .o_wdata(o_wdata), .o_done(o_done), .o_err(o_err), .rdata(rdata),
        .dmr(dmr), .sack(sack), .rply(rply), .dmgo(dmgo),
        .sync(sync), .din(din), .dout(dout), .wtbt(wtbt),
        .ad_o(ad_o), .ad_oe(ad_oe), .ad_i(ad_i)
    );

    // Pulses are tallied just before each rising edge, while they are stable
    always @(posedge clk) begin
        if (f_done === 1'b1) f_done_cnt++;
        if (o_done === 1'b1) o_done_cnt++;
        if (f_err === 1'b1) f_err_cnt++;
        if (o_err === 1'b1) o_err_cnt++;
        if (int'(f_done === 1'b1) + int'(o_done === 1'b1) + int'(f_err === 1'b1) + int'(o_err === 1'b1) > 1)
            multi_pulse = 1'b1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Plays the slave for one granted cycle; the reply arrives 3 clocks after the strobe
    task automatic serve(input string tag, input logic is_o, input logic [15:0] exp_addr,
                         input logic is_wr, input logic is_byte, input logic [15:0] exp_wdata,
                         input logic [15:0] reply_data);
        int n;
        n = 0;
        while (!(ad_oe === 1'b1 && sync === 1'b1) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_addr_seen"}, 16'(n < 40), 16'd1);
        check({tag, "_ad_o_addr"}, ad_o, exp_addr);
        check({tag, "_wtbt_addr"}, 16'(wtbt), 16'(!is_wr));
        @(negedge clk);
        check({tag, "_sync_low"}, 16'(sync), 16'd0);
        if (is_wr) begin
            check({tag, "_dout_low"}, 16'(dout), 16'd0);
            check({tag, "_ad_oe_wr"}, 16'(ad_oe), 16'd1);
            check({tag, "_ad_o_data"}, ad_o, exp_wdata);
        end else begin
            check({tag, "_din_low"}, 16'(din), 16'd0);
            check({tag, "_ad_oe_rd"}, 16'(ad_oe), 16'd0);
        end
        check({tag, "_wtbt_data"}, 16'(wtbt), 16'(!is_byte));
        repeat (3) @(negedge clk);
        rply = 1'b0;
        ad_i = reply_data;
        n = 0;
        while (!(f_done === 1'b1 || o_done === 1'b1 || f_err === 1'b1 || o_err === 1'b1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 16'(n < 20), 16'd1);
        check({tag, "_o_done"}, 16'(o_done), 16'(is_o));
        check({tag, "_f_done"}, 16'(f_done), 16'(!is_o));
        check({tag, "_errs"}, 16'({f_err, o_err}), 16'd0);
        if (!is_wr) check({tag, "_rdata"}, rdata, reply_data);
        if (is_o) o_req = 1'b0;
        else f_req = 1'b0;
        rply = 1'b1;
        ad_i = 16'h0000;
        @(negedge clk);
        check({tag, "_pulse_gone"}, 16'({f_done, o_done}), 16'd0);
        check({tag, "_sync_held"}, 16'(sync), 16'd0);
        n = 0;
        while (sync !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_released"}, 16'(n < 10), 16'd1);
    endtask

    initial begin
        int n;
        int fd0, od0;
        reset = 1'b0;
        f_req = 1'b0; o_req = 1'b0; o_wr = 1'b0; o_byte = 1'b0;
        f_addr = '0; o_addr = '0; o_wdata = '0; ad_i = '0;
        dmr = 1'b1; sack = 1'b1; rply = 1'b1;
        #2;
        check("rst_strobes", 16'({sync, din, dout, wtbt, dmgo}), 16'h001F);
        check("rst_ad_oe", 16'(ad_oe), 16'd0);
        check("rst_pulses", 16'({f_done, f_err, o_done, o_err}), 16'd0);
        check("rst_rdata", rdata, 16'h0000);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // 1: fetch read
        f_req = 1'b1; f_addr = 16'hE0C0;
        serve("t1", 1'b0, 16'hE0C0, 1'b0, 1'b0, 16'h0000, 16'h1234);

        // 2: operand byte write, fetch must stay idle
        fd0 = f_done_cnt;
        o_req = 1'b1; o_wr = 1'b1; o_byte = 1'b1; o_addr = 16'h0100; o_wdata = 16'hAA55;
        serve("t2", 1'b1, 16'h0100, 1'b1, 1'b1, 16'hAA55, 16'h0000);
        check("t2_rdata_held", rdata, 16'h1234);
        check("t2_fetch_quiet", 16'(f_done_cnt - fd0), 16'd0);

        // 3: simultaneous requests, operand wins
        fd0 = f_done_cnt; od0 = o_done_cnt;
        o_wr = 1'b0; o_byte = 1'b0; o_addr = 16'h0200; f_addr = 16'h0300;
        o_req = 1'b1; f_req = 1'b1;
        serve("t3o", 1'b1, 16'h0200, 1'b0, 1'b0, 16'h0000, 16'h2222);
        serve("t3f", 1'b0, 16'h0300, 1'b0, 1'b0, 16'h0000, 16'h3333);
        check("t3_o_once", 16'(o_done_cnt - od0), 16'd1);
        check("t3_f_once", 16'(f_done_cnt - fd0), 16'd1);

        // 4: no reply; counter runs 0..63 in RD so 64 read clocks precede the error
        f_req = 1'b1; f_addr = 16'h2000;
        n = 0;
        while (din !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        check("t4_rd_seen", 16'(n < 20), 16'd1);
        n = 0;
        while (f_err !== 1'b1 && n < 200) begin
            if (din === 1'b0) n++;
            @(negedge clk);
        end
        check("t4_rd_clks", 16'(n), 16'd64);
        check("t4_err_strobes", 16'({sync, din, dout, ad_oe}), 16'h000E);
        f_req = 1'b0;
        @(negedge clk);
        check("t4_err_gone", 16'(f_err), 16'd0);
        o_req = 1'b1; o_wr = 1'b0; o_byte = 1'b0; o_addr = 16'h3000;
        serve("t4b", 1'b1, 16'h3000, 1'b0, 1'b0, 16'h0000, 16'hBEEF);

        // 5: DMA request arrives mid-read
        f_req = 1'b1; f_addr = 16'h4000;
        n = 0;
        while (din !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        check("t5_rd_seen", 16'(n < 20), 16'd1);
        dmr = 1'b0;
        repeat (3) @(negedge clk);
        rply = 1'b0; ad_i = 16'h5A5A;
        n = 0;
        while (f_done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check("t5_read_done", 16'(n < 20), 16'd1);
        check("t5_rdata", rdata, 16'h5A5A);
        f_req = 1'b0; rply = 1'b1; ad_i = 16'h0000;
        n = 0;
        while (dmgo !== 1'b0 && n < 10) begin @(negedge clk); n++; end
        check("t5_dmgo_low", 16'(n < 10), 16'd1);
        f_req = 1'b1; f_addr = 16'h4002;
        repeat (3) @(negedge clk);
        check("t5_wait_sack", 16'({dmgo, ad_oe, sync}), 16'h0001);
        sack = 1'b0;
        n = 0;
        while (dmgo !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        check("t5_dmgo_high", 16'(n < 10), 16'd1);
        check("t5_bus_released", 16'({sync, din, dout, wtbt, ad_oe}), 16'h001E);
        repeat (3) @(negedge clk);
        check("t5_dma_held", 16'({dmgo, sync, ad_oe}), 16'h0006);
        sack = 1'b1; dmr = 1'b1;
        serve("t5b", 1'b0, 16'h4002, 1'b0, 1'b0, 16'h0000, 16'h0F0F);

        // 6: reset asserted during a write cycle
        fd0 = f_done_cnt + f_err_cnt; od0 = o_done_cnt + o_err_cnt;
        o_req = 1'b1; o_wr = 1'b1; o_byte = 1'b0; o_addr = 16'h5000; o_wdata = 16'h1111;
        n = 0;
        while (dout !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        check("t6_wr_seen", 16'(n < 20), 16'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_strobes", 16'({sync, dout, ad_oe}), 16'h0006);
        check("t6_rst_pulses", 16'({o_done, o_err}), 16'd0);
        o_req = 1'b0; o_wr = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_no_pulse", 16'((o_done_cnt + o_err_cnt - od0) + (f_done_cnt + f_err_cnt - fd0)), 16'd0);
        check("t6_rdata_clr", rdata, 16'h0000);
        check("t6_idle", 16'({sync, ad_oe, dmgo}), 16'h0005);

        check("one_pulse_per_clk", 16'(multi_pulse), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
